// File: rtl/gen_capture.sv
// Capture front-end: launches a streaming generator and buffers its words
// in a show-ahead FIFO, with stall or drop policy when the FIFO fills.
module gen_capture #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int MAX_WORDS     = 0,
  parameter int STALL_ON_FULL = 1
) (
  input  logic                       __clock,
  input  logic                       __reset,
  input  logic                       cmd_start,
  input  logic                       cmd_abort,
  output logic                       gen_start,
  output logic                       gen_ready,
  input  logic                       gen_valid,
  input  logic                       gen_done,
  input  logic [WIDTH-1:0]           gen_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       run_done,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [31:0]      wcnt;
  logic [31:0]      wcnt_nxt;

  logic acc;
  logic pop;
  logic push;
  logic drop;
  logic start_clr;
  logic limit_hit;
  logic idle_like;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // LAUNCH always has room: the start edge empties the FIFO.
  always_comb begin
    gen_ready = 1'b0;
    unique case (state)
      LAUNCH:  gen_ready = 1'b1;
      RUN:     gen_ready = (STALL_ON_FULL != 0) ? ~full : 1'b1;
      default: gen_ready = 1'b0;
    endcase
  end

  assign idle_like = (state == IDLE) || (state == DONE);
  assign start_clr = cmd_start & ~cmd_abort & idle_like;

  assign acc  = gen_valid & gen_ready;
  assign pop  = rd_en & ~empty;
  assign push = acc & (~full | pop);
  assign drop = acc & full & ~pop;

  assign wcnt_nxt  = (acc && wcnt != 32'hFFFF_FFFF) ? wcnt + 32'd1 : wcnt;
  assign limit_hit = (MAX_WORDS != 0) && (wcnt_nxt >= 32'(MAX_WORDS));

  always_ff @(posedge __clock or posedge __reset) begin
    if (__reset) begin
      state     <= IDLE;
      gen_start <= 1'b0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
    end else if (cmd_abort) begin
      state     <= IDLE;
      gen_start <= 1'b0;
      busy      <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (cmd_start) begin
            state     <= LAUNCH;
            gen_start <= 1'b1;
            busy      <= 1'b1;
            run_done  <= 1'b0;
          end
        end
        LAUNCH: begin
          state     <= RUN;
          gen_start <= 1'b0;
        end
        RUN: begin
          if (gen_done || limit_hit) begin
            state    <= DONE;
            busy     <= 1'b0;
            run_done <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gen_start <= 1'b0;
          busy      <= 1'b0;
          run_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge __clock or posedge __reset) begin
    if (__reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      overflow <= 1'b0;
    end else if (start_clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (drop && STALL_ON_FULL == 0) overflow <= 1'b1;
      wcnt <= wcnt_nxt;
    end
  end

  // Storage is not reset; rd_data is masked while empty instead.
  always_ff @(posedge __clock) begin
    if (push) mem[wr_ptr] <= gen_data;
  end

endmodule

// File: tb/tb_gen_capture.sv
// Bench for gen_capture: table vectors on a 16-deep instance plus directed
// sequences for stall, drop, word limit, abort and async reset.
module tb_gen_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] cs = '0;
  logic [3:0] ab = '0;
  logic [3:0] gv = '0;
  logic [3:0] gd = '0;
  logic [3:0] re = '0;
  logic [31:0] gdat [4];

  wire [3:0] gs, gr, emp, ful, bsy, rdn, ovf;
  wire [31:0] rdat [4];
  wire [4:0] cnt0, cnt3;
  wire [2:0] cnt1, cnt2;

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  gen_capture #(.WIDTH(32), .DEPTH(16), .MAX_WORDS(0), .STALL_ON_FULL(1)) u0 (
    .__clock(clk), .__reset(rst), .cmd_start(cs[0]), .cmd_abort(ab[0]),
    .gen_start(gs[0]), .gen_ready(gr[0]), .gen_valid(gv[0]), .gen_done(gd[0]),
    .gen_data(gdat[0]), .rd_en(re[0]), .rd_data(rdat[0]), .empty(emp[0]),
    .full(ful[0]), .count(cnt0), .busy(bsy[0]), .run_done(rdn[0]),
    .overflow(ovf[0]));

  gen_capture #(.WIDTH(32), .DEPTH(4), .MAX_WORDS(0), .STALL_ON_FULL(1)) u1 (
    .__clock(clk), .__reset(rst), .cmd_start(cs[1]), .cmd_abort(ab[1]),
    .gen_start(gs[1]), .gen_ready(gr[1]), .gen_valid(gv[1]), .gen_done(gd[1]),
    .gen_data(gdat[1]), .rd_en(re[1]), .rd_data(rdat[1]), .empty(emp[1]),
    .full(ful[1]), .count(cnt1), .busy(bsy[1]), .run_done(rdn[1]),
    .overflow(ovf[1]));

  gen_capture #(.WIDTH(32), .DEPTH(4), .MAX_WORDS(0), .STALL_ON_FULL(0)) u2 (
    .__clock(clk), .__reset(rst), .cmd_start(cs[2]), .cmd_abort(ab[2]),
    .gen_start(gs[2]), .gen_ready(gr[2]), .gen_valid(gv[2]), .gen_done(gd[2]),
    .gen_data(gdat[2]), .rd_en(re[2]), .rd_data(rdat[2]), .empty(emp[2]),
    .full(ful[2]), .count(cnt2), .busy(bsy[2]), .run_done(rdn[2]),
    .overflow(ovf[2]));

  gen_capture #(.WIDTH(32), .DEPTH(16), .MAX_WORDS(3), .STALL_ON_FULL(1)) u3 (
    .__clock(clk), .__reset(rst), .cmd_start(cs[3]), .cmd_abort(ab[3]),
    .gen_start(gs[3]), .gen_ready(gr[3]), .gen_valid(gv[3]), .gen_done(gd[3]),
    .gen_data(gdat[3]), .rd_en(re[3]), .rd_data(rdat[3]), .empty(emp[3]),
    .full(ful[3]), .count(cnt3), .busy(bsy[3]), .run_done(rdn[3]),
    .overflow(ovf[3]));

  // in = {cmd_start, cmd_abort, gen_valid, gen_done, rd_en}
  // ex = {gen_start, gen_ready, busy, run_done, empty}
  typedef struct {
    logic [4:0]  in;
    logic [31:0] d;
    logic [4:0]  ex;
    logic [4:0]  c;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    int sent;
    int rcv;
    logic acc;
    logic [31:0] drain [4];

    for (int i = 0; i < 4; i++) gdat[i] = '0;

    tbl[0]  = '{5'b10000, 32'd0, 5'b11101, 5'd0, 32'd0};
    tbl[1]  = '{5'b00100, 32'd1, 5'b01100, 5'd1, 32'd1};
    tbl[2]  = '{5'b00100, 32'd1, 5'b01100, 5'd2, 32'd1};
    tbl[3]  = '{5'b00100, 32'd2, 5'b01100, 5'd3, 32'd1};
    tbl[4]  = '{5'b00100, 32'd3, 5'b01100, 5'd4, 32'd1};
    tbl[5]  = '{5'b00110, 32'd5, 5'b00010, 5'd5, 32'd1};
    tbl[6]  = '{5'b00001, 32'd0, 5'b00010, 5'd4, 32'd1};
    tbl[7]  = '{5'b00001, 32'd0, 5'b00010, 5'd3, 32'd2};
    tbl[8]  = '{5'b00001, 32'd0, 5'b00010, 5'd2, 32'd3};
    tbl[9]  = '{5'b00001, 32'd0, 5'b00010, 5'd1, 32'd5};
    tbl[10] = '{5'b00001, 32'd0, 5'b00011, 5'd0, 32'd0};
    tbl[11] = '{5'b00001, 32'd0, 5'b00011, 5'd0, 32'd0};
    tbl[12] = '{5'b11000, 32'd0, 5'b00001, 5'd0, 32'd0};
    tbl[13] = '{5'b10000, 32'd0, 5'b11101, 5'd0, 32'd0};
    tbl[14] = '{5'b01000, 32'd0, 5'b00001, 5'd0, 32'd0};

    // reset state before any clock edge
    #2;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_flags%0d", i),
          64'({gs[i], gr[i], bsy[i], rdn[i], emp[i], ful[i], ovf[i]}),
          64'(7'b0000100));
      chk($sformatf("reset_rd%0d", i), 64'(rdat[i]), 64'd0);
    end
    chk("reset_cnt", 64'({cnt0, cnt1, cnt2, cnt3}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // basic capture and edge cases on the 16-deep instance
    for (int i = 0; i < 15; i++) begin
      {cs[0], ab[0], gv[0], gd[0], re[0]} = tbl[i].in;
      gdat[0] = tbl[i].d;
      step();
      chk($sformatf("vec%0d", i),
          64'({gs[0], gr[0], bsy[0], rdn[0], emp[0], cnt0, rdat[0]}),
          64'({tbl[i].ex, tbl[i].c, tbl[i].rd}));
    end
    {cs[0], ab[0], gv[0], gd[0], re[0]} = 5'b0;

    // backpressure, DEPTH=4
    cs[1] = 1'b1;
    step();
    cs[1] = 1'b0;
    chk("stall_launch", 64'(gs[1]), 64'd1);
    gv[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      gdat[1] = 32'(k);
      step();
    end
    chk("stall_full", 64'({cnt1, gr[1], ful[1], ovf[1]}), 64'({3'd4, 3'b010}));
    gdat[1] = 32'd4;
    step();
    step();
    chk("stall_hold", 64'({cnt1, gr[1]}), 64'({3'd4, 1'b0}));
    re[1] = 1'b1;
    step();
    re[1] = 1'b0;
    chk("stall_reready", 64'({gr[1], cnt1, rdat[1]}), 64'({1'b1, 3'd3, 32'd1}));
    sent = 4;
    rcv = 1;
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      gv[1] = (sent < 10);
      gdat[1] = 32'(sent);
      re[1] = ~emp[1];
      acc = gv[1] & gr[1];
      if (re[1]) begin
        chk($sformatf("stall_rd%0d", rcv), 64'(rdat[1]), 64'(rcv));
        rcv++;
      end
      step();
      if (acc) sent++;
    end
    gv[1] = 1'b0;
    re[1] = 1'b0;
    chk("stall_all_read", 64'(rcv), 64'd10);
    gd[1] = 1'b1;
    step();
    gd[1] = 1'b0;
    chk("stall_done", 64'({rdn[1], ovf[1], emp[1]}), 64'(3'b101));

    // drop mode, DEPTH=4
    cs[2] = 1'b1;
    step();
    cs[2] = 1'b0;
    gv[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      gdat[2] = 32'(k);
      step();
    end
    chk("drop_full", 64'({cnt2, ovf[2], gr[2], rdat[2]}),
        64'({3'd4, 2'b11, 32'd0}));
    gdat[2] = 32'd6;
    re[2] = 1'b1;
    step();
    gv[2] = 1'b0;
    re[2] = 1'b0;
    chk("drop_pushpop", 64'({cnt2, ful[2], ovf[2], rdat[2]}),
        64'({3'd4, 2'b11, 32'd1}));
    drain = '{32'd1, 32'd2, 32'd3, 32'd6};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drop_rd%0d", k), 64'(rdat[2]), 64'(drain[k]));
      re[2] = 1'b1;
      step();
      re[2] = 1'b0;
    end
    chk("drop_empty", 64'({emp[2], cnt2}), 64'({1'b1, 3'd0}));

    // word limit, MAX_WORDS=3
    cs[3] = 1'b1;
    step();
    cs[3] = 1'b0;
    gv[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gdat[3] = 32'(10 + k);
      step();
    end
    chk("limit_done", 64'({rdn[3], gr[3], bsy[3], cnt3}),
        64'({3'b100, 5'd3}));
    gdat[3] = 32'd13;
    step();
    gv[3] = 1'b0;
    chk("limit_hold", 64'({cnt3, rdat[3]}), 64'({5'd3, 32'd10}));

    // abort during RUN keeps FIFO
    cs[3] = 1'b1;
    step();
    cs[3] = 1'b0;
    chk("restart_clear", 64'({cnt3, emp[3], gs[3]}), 64'({5'd0, 2'b11}));
    gv[3] = 1'b1;
    gdat[3] = 32'd20;
    step();
    gdat[3] = 32'd21;
    step();
    gv[3] = 1'b0;
    chk("pre_abort_run", 64'({bsy[3], rdn[3], cnt3}), 64'({2'b10, 5'd2}));
    ab[3] = 1'b1;
    step();
    ab[3] = 1'b0;
    chk("abort_idle", 64'({gs[3], gr[3], bsy[3], rdn[3], cnt3, rdat[3]}),
        64'({4'b0000, 5'd2, 32'd20}));

    // asynchronous reset between edges
    cs[3] = 1'b1;
    step();
    cs[3] = 1'b0;
    gv[3] = 1'b1;
    gdat[3] = 32'd30;
    step();
    gv[3] = 1'b0;
    chk("pre_reset_run", 64'({bsy[3], cnt3}), 64'({1'b1, 5'd1}));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst",
        64'({gs[3], gr[3], bsy[3], rdn[3], emp[3], ful[3], ovf[3], cnt3, rdat[3]}),
        64'({7'b0000100, 5'd0, 32'd0}));
    chk("async_rst_ovf", 64'({ovf[2], cnt2}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    cs[3] = 1'b1;
    step();
    cs[3] = 1'b0;
    chk("post_rst_launch", 64'({gs[3], gr[3], bsy[3]}), 64'(3'b111));
    gv[3] = 1'b1;
    gdat[3] = 32'd40;
    step();
    gv[3] = 1'b0;
    chk("post_rst_capture", 64'({cnt3, rdat[3], bsy[3]}),
        64'({5'd1, 32'd40, 1'b1}));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
